// File: rtl/inv_addkey_stage_if.sv
// ---------------------------------------------------------------------------
// inv_addkey_stage_if
//   Bus bundle for the inverse-cipher AddRoundKey stage.
//
//   Key load port   : key_we, key_addr, key_wdata
//   Upstream beat   : in_valid, in_ready, in_data, in_first
//   Downstream beat : out_valid, out_ready, out_data, out_round, out_mix,
//                     out_last
//
//   master : the environment (key loader, upstream producer, downstream sink)
//   slave  : the stage itself
//
//   Data vectors use ascending bit order [0:DW-1]; byte 0 is bits 0..7.
// ---------------------------------------------------------------------------
interface inv_addkey_stage_if #(
  parameter int DW = 128
);
  // Round-key load port
  logic          key_we;
  logic [3:0]    key_addr;
  logic [0:DW-1] key_wdata;

  // Upstream state beats
  logic          in_valid;
  logic          in_ready;
  logic [0:DW-1] in_data;
  logic          in_first;

  // Downstream state beats
  logic          out_valid;
  logic          out_ready;
  logic [0:DW-1] out_data;
  logic [3:0]    out_round;
  logic          out_mix;
  logic          out_last;

  modport master (
    output key_we, key_addr, key_wdata,
    output in_valid, in_data, in_first,
    input  in_ready,
    output out_ready,
    input  out_valid, out_data, out_round, out_mix, out_last
  );

  modport slave (
    input  key_we, key_addr, key_wdata,
    input  in_valid, in_data, in_first,
    output in_ready,
    input  out_ready,
    output out_valid, out_data, out_round, out_mix, out_last
  );
endinterface

// File: rtl/inv_addkey_stage.sv
// ---------------------------------------------------------------------------
// inv_addkey_stage
//   Registered AddRoundKey stage for the AES-128 inverse cipher.
//
//   An (NR+1)-entry round-key buffer is loaded through the key port. State
//   beats of one block arrive in decryption order: the beat flagged in_first
//   is XORed with key[NR], each following beat with the next lower key down
//   to key[0]. Every result is registered and tagged with the key index that
//   was applied; out_mix marks results that continue into inv_mixcol
//   (rounds NR-1..1), out_last marks the plaintext beat (round 0).
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : inv_addkey_stage_if.slave (key port, in/out beat handshakes)
//     busy   : a block is in progress and rounds remain
//     err    : sticky protocol error (orphan beat, restart while busy,
//              out-of-range key write); cleared only by reset
// ---------------------------------------------------------------------------
module inv_addkey_stage #(
  parameter int NR = 10,
  parameter int DW = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  inv_addkey_stage_if.slave bus,
  output logic              busy,
  output logic              err
);

  // Key index width is fixed by the 4-bit key_addr / out_round ports.
  localparam int KW = 4;
  typedef logic [KW-1:0] kidx_t;

  localparam kidx_t KIDX_TOP    = kidx_t'(NR);
  localparam kidx_t KIDX_NEXT   = kidx_t'(NR - 1);
  localparam kidx_t KIDX_BOTTOM = '0;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [0:DW-1] key_mem [0:NR];   // round-key buffer, index = round
  kidx_t         rnd;              // key index for the next non-first beat

  logic          out_valid_q;
  logic [0:DW-1] out_data_q;
  kidx_t         out_round_q;
  logic          out_mix_q;
  logic          out_last_q;

  // -------------------------------------------------------------------------
  // Handshake and beat classification
  // -------------------------------------------------------------------------
  logic          accept;       // beat taken from upstream this cycle
  logic          produce;      // accepted beat yields an output
  logic          restart;      // accepted beat starts a new block
  logic          proto_err;    // orphan beat or restart while busy
  kidx_t         kidx;         // key index applied to the accepted beat
  logic [0:DW-1] sel_key;
  logic          key_addr_bad;
  logic          key_write;

  // The output register can take a new beat whenever it is empty or is
  // being drained in this same cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    kidx      = rnd;
    produce   = 1'b0;
    restart   = 1'b0;
    proto_err = 1'b0;
    if (accept) begin
      if (bus.in_first) begin
        // A first beat always restarts at the top key; if a block was
        // still running its remaining rounds are abandoned.
        kidx      = KIDX_TOP;
        produce   = 1'b1;
        restart   = 1'b1;
        proto_err = busy;
      end else if (busy) begin
        produce   = 1'b1;
      end else begin
        // Beat without a block in progress: swallowed, no output.
        proto_err = 1'b1;
      end
    end
  end

  // Combinational read of the buffer happens before this edge's write
  // lands, so a same-index write and use sees the old key.
  assign sel_key      = key_mem[kidx];

  assign key_addr_bad = bus.key_addr > KIDX_TOP;
  assign key_write    = bus.key_we && !key_addr_bad;

  // -------------------------------------------------------------------------
  // Round-key buffer
  // -------------------------------------------------------------------------
  // NOTE: the buffer is built from flops and cleared on reset so a block
  // started after reset never sees keys from before it; a RAM macro could
  // not provide that clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) begin
        key_mem[i] <= '0;
      end
    end else if (key_write) begin
      key_mem[bus.key_addr] <= bus.key_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Block sequencing and error flag
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      rnd  <= KIDX_BOTTOM;
      err  <= 1'b0;
    end else begin
      if (restart) begin
        busy <= 1'b1;
        rnd  <= KIDX_NEXT;
      end else if (produce) begin
        // Round 0 closes the block; otherwise step down one key.
        if (rnd == KIDX_BOTTOM) begin
          busy <= 1'b0;
        end else begin
          rnd <= rnd - kidx_t'(1);
        end
      end

      if (proto_err || (bus.key_we && key_addr_bad)) begin
        err <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_round_q <= KIDX_BOTTOM;
      out_mix_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (produce) begin
      // A simultaneous drain and accept keeps out_valid high and replaces
      // the contents with the new beat.
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in_data ^ sel_key;
      out_round_q <= kidx;
      out_mix_q   <= (kidx != KIDX_BOTTOM) && (kidx != KIDX_TOP);
      out_last_q  <= (kidx == KIDX_BOTTOM);
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_round = out_round_q;
  assign bus.out_mix   = out_mix_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_inv_addkey_stage.sv
// ---------------------------------------------------------------------------
// tb_inv_addkey_stage
//   Directed FIPS-197 sequences, stall/abort/key-collision/reset scenarios,
//   then a randomized phase. A cycle-level reference model of the stage's
//   rules predicts every output after each clock edge.
// ---------------------------------------------------------------------------
module tb_inv_addkey_stage;

  localparam int NR = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inv_addkey_stage_if b ();

  inv_addkey_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b),
    .busy  (busy),
    .err   (err)
  );

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  logic [0:127] m_keys [0:NR];
  logic         m_busy;
  int           m_rnd;
  logic         m_err;
  logic         m_ov;
  logic [0:127] m_od;
  int           m_or;
  logic         m_mix;
  logic         m_last;

  task automatic model_reset();
    for (int i = 0; i <= NR; i++) m_keys[i] = '0;
    m_busy = 1'b0;
    m_rnd  = 0;
    m_err  = 1'b0;
    m_ov   = 1'b0;
    m_od   = '0;
    m_or   = 0;
    m_mix  = 1'b0;
    m_last = 1'b0;
  endtask

  // Applies one clock edge worth of rules to the model using the inputs
  // currently driven.
  task automatic model_step();
    logic rdy;
    logic acc;
    logic prod;
    int   k;
    rdy  = !m_ov || b.out_ready;
    acc  = b.in_valid && rdy;
    prod = 1'b0;
    k    = 0;
    if (acc) begin
      if (b.in_first) begin
        if (m_busy) m_err = 1'b1;
        k      = NR;
        prod   = 1'b1;
        m_busy = 1'b1;
        m_rnd  = NR - 1;
      end else if (m_busy) begin
        k    = m_rnd;
        prod = 1'b1;
        if (m_rnd == 0) m_busy = 1'b0;
        else            m_rnd  = m_rnd - 1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (prod) begin
      m_ov   = 1'b1;
      m_od   = b.in_data ^ m_keys[k];
      m_or   = k;
      m_mix  = (k > 0) && (k < NR);
      m_last = (k == 0);
    end else if (b.out_ready) begin
      m_ov = 1'b0;
    end
    if (b.key_we) begin
      if (b.key_addr <= 4'(NR)) m_keys[b.key_addr] = b.key_wdata;
      else                      m_err = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  task automatic check(input string tag, input logic [0:127] obs,
                       input logic [0:127] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ":out_valid"}, b.out_valid, m_ov);
    check({tag, ":out_data"},  b.out_data,  m_od);
    check({tag, ":out_round"}, b.out_round, m_or);
    check({tag, ":out_mix"},   b.out_mix,   m_mix);
    check({tag, ":out_last"},  b.out_last,  m_last);
    check({tag, ":busy"},      busy,        m_busy);
    check({tag, ":err"},       err,         m_err);
    check({tag, ":in_ready"},  b.in_ready,  !m_ov || b.out_ready);
  endtask

  // One clock: model follows the inputs, outputs are compared 1 time unit
  // after the rising edge.
  task automatic tick(input string tag);
    if (!rst_n) model_reset();
    else        model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle();
    b.in_valid  = 1'b0;
    b.in_first  = 1'b0;
    b.in_data   = '0;
    b.key_we    = 1'b0;
    b.key_addr  = '0;
    b.key_wdata = '0;
  endtask

  task automatic beat(input logic first, input logic [0:127] d, input string tag);
    b.in_valid = 1'b1;
    b.in_first = first;
    b.in_data  = d;
    tick(tag);
  endtask

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Keys as loaded by the directed part of the bench.
  logic [0:127] kexp [0:NR];
  logic [0:127] d;
  logic [0:127] held;
  logic [0:127] ones;
  logic [0:127] old9;

  initial begin
    ones = '1;
    rst_n = 1'b0;
    idle();
    b.out_ready = 1'b1;
    model_reset();

    // ---- reset state ----
    tick("rst0");
    tick("rst1");
    rst_n = 1'b1;

    // ---- load FIPS-197 C.1 keys 10 and 0, random middle keys ----
    kexp[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    kexp[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    for (int i = 1; i < NR; i++) kexp[i] = rand128();
    for (int i = 0; i <= NR; i++) begin
      b.key_we    = 1'b1;
      b.key_addr  = 4'(i);
      b.key_wdata = kexp[i];
      tick("kload");
    end
    idle();

    // ---- FIPS block ----
    beat(1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, "fips10");
    check("fips10_data",  b.out_data, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
    check("fips10_round", b.out_round, 10);
    check("fips10_mix",   b.out_mix, 1'b0);
    check("fips10_last",  b.out_last, 1'b0);
    for (int r = 9; r >= 1; r--) begin
      beat(1'b0, rand128(), "fips_mid");
      check("fips_mid_round", b.out_round, r);
      check("fips_mid_mix",   b.out_mix, 1'b1);
    end
    beat(1'b0, 128'h00102030405060708090a0b0c0d0e0f0, "fips0");
    check("fips0_data",  b.out_data, 128'h00112233445566778899aabbccddeeff);
    check("fips0_round", b.out_round, 0);
    check("fips0_last",  b.out_last, 1'b1);
    check("fips0_busy",  busy, 1'b0);
    idle();
    tick("gap0");

    // ---- back-pressure ----
    d = rand128();
    held = d ^ kexp[10];
    beat(1'b1, d, "stall10");
    b.out_ready = 1'b0;
    d = rand128();
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, d, "stall_hold");
      check("stall_in_ready", b.in_ready, 1'b0);
      check("stall_data",     b.out_data, held);
      check("stall_round",    b.out_round, 10);
    end
    b.out_ready = 1'b1;
    beat(1'b0, d, "stall_rel");
    check("stall_rel_data",  b.out_data, d ^ kexp[9]);
    check("stall_rel_round", b.out_round, 9);
    for (int r = 8; r >= 6; r--) begin
      beat(1'b0, rand128(), "stall_run");
      check("stall_run_round", b.out_round, r);
    end

    // ---- restart mid-block (next round would be 5) ----
    beat(1'b1, rand128(), "abort");
    check("abort_err",   err, 1'b1);
    check("abort_round", b.out_round, 10);
    for (int r = 9; r >= 0; r--) begin
      beat(1'b0, rand128(), "abort_run");
      check("abort_run_round", b.out_round, r);
    end
    check("abort_busy", busy, 1'b0);

    // ---- key write colliding with a round-9 beat ----
    beat(1'b1, rand128(), "kc10");
    old9 = kexp[9];
    b.key_we    = 1'b1;
    b.key_addr  = 4'd9;
    b.key_wdata = ones;
    beat(1'b0, '0, "kc9");
    check("kc9_old_key", b.out_data, old9);
    b.key_we = 1'b0;
    for (int r = 8; r >= 0; r--) beat(1'b0, rand128(), "kc_run");
    beat(1'b1, rand128(), "kc2_10");
    beat(1'b0, '0, "kc2_9");
    check("kc2_9_new_key", b.out_data, ones);
    for (int r = 8; r >= 0; r--) beat(1'b0, rand128(), "kc2_run");

    // ---- reset mid-block ----
    beat(1'b1, rand128(), "mr10");
    beat(1'b0, rand128(), "mr9");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("mid_rst");
    check("mid_rst_valid", b.out_valid, 1'b0);
    check("mid_rst_busy",  busy, 1'b0);
    idle();
    tick("mid_rst_hold");
    rst_n = 1'b1;
    beat(1'b0, rand128(), "orphan");
    check("orphan_valid", b.out_valid, 1'b0);
    check("orphan_err",   err, 1'b1);
    idle();

    // ---- out-of-range key address ----
    rst_n = 1'b0;
    tick("rst2");
    rst_n = 1'b1;
    b.key_we    = 1'b1;
    b.key_addr  = 4'd12;
    b.key_wdata = rand128();
    tick("kbad");
    check("kbad_err", err, 1'b1);
    idle();
    // Keys were cleared by reset: a block passes data through unchanged
    // except where the model says otherwise.
    d = rand128();
    beat(1'b1, d, "zero_key");
    check("zero_key_data", b.out_data, d);

    // ---- randomized phase ----
    rst_n = 1'b0;
    tick("rst3");
    rst_n = 1'b1;
    for (int n = 0; n < 600; n++) begin
      b.in_valid    = ($urandom_range(0, 3) != 0);
      b.in_first    = m_busy ? ($urandom_range(0, 19) == 0)
                             : ($urandom_range(0, 7) != 0);
      b.in_data     = rand128();
      b.out_ready   = ($urandom_range(0, 3) != 0);
      b.key_we      = ($urandom_range(0, 5) == 0);
      b.key_addr    = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15))
                                                  : 4'($urandom_range(0, NR));
      b.key_wdata   = rand128();
      tick("rand");
    end
    idle();
    b.out_ready = 1'b1;
    tick("drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
